// File: rtl/mem_arbiter.sv
// Frame-buffer RAM arbiter: grants one engine at a time and issues a single RAM access per grant.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module mem_arbiter #(
  parameter int unsigned N_ENG = 5,
  parameter int unsigned AW    = 16,
  parameter int unsigned DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic [N_ENG*DW-1:0]      eng_data,
  input  logic [N_ENG*AW-1:0]      eng_addr,
  input  logic [N_ENG*(DW/8)-1:0]  eng_wben,
  input  logic [N_ENG-1:0]         eng_op,
  input  logic [N_ENG-1:0]         eng_rts,
  output logic [N_ENG-1:0]         eng_rtr,
  output logic [DW-1:0]            bcast_data,
  output logic [N_ENG-1:0]         bcast_xfc,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  output logic [DW/8-1:0]          mem_wben,
  input  logic [DW-1:0]            mem_rdata
);

  localparam int unsigned BW = DW / 8;
  localparam int unsigned IW = (N_ENG > 1) ? $clog2(N_ENG) : 1;

  typedef enum logic [2:0] {StIdle, StOffer, StIssue, StWait, StDone} state_e;

  state_e          state;
  logic [IW-1:0]   grant;
  logic [IW-1:0]   win;
  logic [N_ENG-1:0] win_oh;
  logic [N_ENG-1:0] grant_oh;

  logic            sel_rts;
  logic            sel_op;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic [BW-1:0]   sel_wben;

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    win = '0;
    for (int k = N_ENG - 1; k >= 0; k--) begin
      if (eng_rts[k]) win = IW'(k);
    end
  end
`else
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] cand;
  logic          found;

  // Search starts just past the last served engine so every requester gets a turn.
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= N_ENG; k++) begin
      cand = IW'((32'(rr_ptr) + k) % N_ENG);
      if (!found && eng_rts[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end
`endif

  assign win_oh   = N_ENG'(1) << win;
  assign grant_oh = N_ENG'(1) << grant;

  always_comb begin
    sel_rts  = 1'b0;
    sel_op   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    sel_wben = '0;
    for (int unsigned i = 0; i < N_ENG; i++) begin
      if (grant == IW'(i)) begin
        sel_rts  = eng_rts[i];
        sel_op   = eng_op[i];
        sel_addr = eng_addr[i*AW +: AW];
        sel_data = eng_data[i*DW +: DW];
        sel_wben = eng_wben[i*BW +: BW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state      <= StIdle;
      grant      <= '0;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr     <= IW'(N_ENG - 1);
`endif
      eng_rtr    <= '0;
      bcast_data <= '0;
      bcast_xfc  <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wben   <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (|eng_rts) begin
            grant   <= win;
            eng_rtr <= win_oh;
            state   <= StOffer;
          end
        end
        StOffer: begin
          eng_rtr <= '0;
          if (sel_rts) begin
            mem_en    <= 1'b1;
            mem_we    <= sel_op;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_data;
            mem_wben  <= sel_op ? sel_wben : '0;
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr    <= grant;
`endif
            state     <= StIssue;
          end else begin
            // Withdrawn request: no access, and the engine keeps its turn.
            state <= StIdle;
          end
        end
        StIssue: begin
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          mem_wben  <= '0;
          if (mem_we) begin
            bcast_xfc <= grant_oh;
            state     <= StDone;
          end else begin
            state <= StWait;
          end
        end
        StWait: begin
          bcast_data <= mem_rdata;
          bcast_xfc  <= grant_oh;
          state      <= StDone;
        end
        StDone: begin
          bcast_xfc <= '0;
          state     <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single write/read, withdrawal, contention, back-to-back, reset.
module tb_mem_arbiter;

  localparam int unsigned N_ENG = 5;
  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 32;
  localparam int unsigned BW    = DW / 8;

  logic                  clk = 1'b0;
  logic                  rst_;
  logic [N_ENG*DW-1:0]   eng_data;
  logic [N_ENG*AW-1:0]   eng_addr;
  logic [N_ENG*BW-1:0]   eng_wben;
  logic [N_ENG-1:0]      eng_op;
  logic [N_ENG-1:0]      eng_rts;
  logic [N_ENG-1:0]      eng_rtr;
  logic [DW-1:0]         bcast_data;
  logic [N_ENG-1:0]      bcast_xfc;
  logic                  mem_en;
  logic                  mem_we;
  logic [AW-1:0]         mem_addr;
  logic [DW-1:0]         mem_wdata;
  logic [BW-1:0]         mem_wben;
  logic [DW-1:0]         mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.N_ENG(N_ENG), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst_       (rst_),
    .eng_data   (eng_data),
    .eng_addr   (eng_addr),
    .eng_wben   (eng_wben),
    .eng_op     (eng_op),
    .eng_rts    (eng_rts),
    .eng_rtr    (eng_rtr),
    .bcast_data (bcast_data),
    .bcast_xfc  (bcast_xfc),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wben   (mem_wben),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: read data only valid the cycle after a read strobe.
  always @(posedge clk) begin
    if (mem_en && !mem_we) begin
      mem_rdata <= (mem_addr == 16'h0020) ? 32'h1234_5678 : {16'hA5A5, mem_addr};
    end else begin
      mem_rdata <= 32'hBAD0_0BAD;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_eng(input int eng, input logic op, input logic [15:0] addr,
                         input logic [31:0] data, input logic [3:0] wben);
    eng_op[eng]              = op;
    eng_addr[eng*AW +: AW]   = addr;
    eng_data[eng*DW +: DW]   = data;
    eng_wben[eng*BW +: BW]   = wben;
    eng_rts[eng]             = 1'b1;
  endtask

  // Starts with the DUT idle in cycle 0; returns in cycle 4 with the DUT idle again.
  task automatic write_txn(input int eng, input logic [15:0] addr, input logic [31:0] data,
                           input logic [3:0] wben, input logic [31:0] exp_bcast);
    logic [N_ENG-1:0] oh;
    oh = 5'b00001 << eng;
    set_eng(eng, 1'b1, addr, data, wben);
    tick();
    check("wr_c1_rtr", eng_rtr, oh);
    check("wr_c1_en", mem_en, 0);
    tick();
    check("wr_c2_en", mem_en, 1);
    check("wr_c2_we", mem_we, 1);
    check("wr_c2_addr", mem_addr, addr);
    check("wr_c2_wdata", mem_wdata, data);
    check("wr_c2_wben", mem_wben, wben);
    check("wr_c2_rtr", eng_rtr, 0);
    check("wr_c2_xfc", bcast_xfc, 0);
    eng_rts[eng] = 1'b0;
    tick();
    check("wr_c3_xfc", bcast_xfc, oh);
    check("wr_c3_en", mem_en, 0);
    check("wr_c3_bcast", bcast_data, exp_bcast);
    tick();
    check("wr_c4_xfc", bcast_xfc, 0);
  endtask

  task automatic read_txn(input int eng, input logic [15:0] addr, input logic [31:0] old_bcast,
                          input logic [31:0] exp_data);
    logic [N_ENG-1:0] oh;
    oh = 5'b00001 << eng;
    set_eng(eng, 1'b0, addr, 32'hFFFF_FFFF, 4'hF);
    tick();
    check("rd_c1_rtr", eng_rtr, oh);
    tick();
    check("rd_c2_en", mem_en, 1);
    check("rd_c2_we", mem_we, 0);
    check("rd_c2_addr", mem_addr, addr);
    check("rd_c2_wben", mem_wben, 0);
    eng_rts[eng] = 1'b0;
    tick();
    check("rd_c3_xfc", bcast_xfc, 0);
    check("rd_c3_en", mem_en, 0);
    check("rd_c3_bcast", bcast_data, old_bcast);
    tick();
    check("rd_c4_xfc", bcast_xfc, oh);
    check("rd_c4_bcast", bcast_data, exp_data);
    tick();
    check("rd_c5_xfc", bcast_xfc, 0);
    check("rd_c5_bcast", bcast_data, exp_data);
  endtask

  initial begin
    logic [N_ENG-1:0] exp_order [6];
    int n_grant;

`ifdef ARB_FIXED_PRIO_EN
    exp_order = '{5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001};
`else
    exp_order = '{5'b00001, 5'b00010, 5'b01000, 5'b00001, 5'b00010, 5'b01000};
`endif

    rst_     = 1'b1;
    eng_data = '0;
    eng_addr = '0;
    eng_wben = '0;
    eng_op   = '0;
    eng_rts  = '0;
    tick();
    tick();
    check("rst_rtr", eng_rtr, 0);
    check("rst_xfc", bcast_xfc, 0);
    check("rst_bcast", bcast_data, 0);
    check("rst_en", mem_en, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wben", mem_wben, 0);
    rst_ = 1'b0;
    tick();

    // Single write, single read, then a write that must leave read data alone.
    write_txn(1, 16'h0010, 32'hDEAD_BEEF, 4'hF, 32'h0);
    read_txn(1, 16'h0020, 32'h0, 32'h1234_5678);
    write_txn(0, 16'h0005, 32'hCAFE_F00D, 4'h3, 32'h1234_5678);

    // Withdrawal: engine 2 drops rts while offered, then keeps its turn over engine 3.
    set_eng(2, 1'b0, 16'h0030, 32'h0, 4'h0);
    tick();
    check("wd_c1_rtr", eng_rtr, 5'b00100);
    eng_rts[2] = 1'b0;
    tick();
    check("wd_c2_en", mem_en, 0);
    check("wd_c2_rtr", eng_rtr, 0);
    check("wd_c2_xfc", bcast_xfc, 0);
    set_eng(3, 1'b1, 16'h0033, 32'h3333_3333, 4'hF);
    write_txn(2, 16'h0032, 32'h2222_2222, 4'hC, 32'h1234_5678);
    write_txn(3, 16'h0033, 32'h3333_3333, 4'hF, 32'h1234_5678);

    // Contention: engines 0, 1 and 3 request continuously.
    set_eng(0, 1'b1, 16'h0100, 32'h0000_0100, 4'hF);
    set_eng(1, 1'b1, 16'h0101, 32'h0000_0101, 4'hF);
    set_eng(3, 1'b1, 16'h0103, 32'h0000_0103, 4'hF);
    n_grant = 0;
    for (int c = 0; c < 60 && n_grant < 6; c++) begin
      tick();
      check("ct_rtr_onehot0", $onehot0(eng_rtr), 1);
      if (bcast_xfc != '0) begin
        check("ct_grant", bcast_xfc, exp_order[n_grant]);
        n_grant++;
      end
    end
    check("ct_grant_count", n_grant, 6);
    eng_rts = '0;
    tick();

    // Back-to-back writes from engine 1, each finishing four cycles after rts.
    for (int i = 0; i < 4; i++) begin
      write_txn(1, 16'(i), 32'hB0B0_0000 + 32'(i), 4'hF, 32'h1234_5678);
    end

    // Reset during the read wait cycle.
    set_eng(1, 1'b0, 16'h0021, 32'h0, 4'hF);
    tick();
    check("rr_c1_rtr", eng_rtr, 5'b00010);
    tick();
    check("rr_c2_en", mem_en, 1);
    eng_rts = '0;
    tick();
    rst_ = 1'b1;
    #1;
    check("rr_async_xfc", bcast_xfc, 0);
    check("rr_async_bcast", bcast_data, 0);
    check("rr_async_en", mem_en, 0);
    check("rr_async_rtr", eng_rtr, 0);
    tick();
    rst_ = 1'b0;
    tick();
    check("rr_post_xfc", bcast_xfc, 0);
    check("rr_post_bcast", bcast_data, 0);
    tick();
    check("rr_post2_xfc", bcast_xfc, 0);

    // Engine 0 regains first priority over engine 3 after reset.
    set_eng(3, 1'b1, 16'h0203, 32'h0000_0203, 4'hF);
    write_txn(0, 16'h0200, 32'h0000_0200, 4'hF, 32'h0);
    write_txn(3, 16'h0203, 32'h0000_0203, 4'hF, 32'h0);
    read_txn(4, 16'h0020, 32'h0, 32'h1234_5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Downstream stage of the drawing engines (fill-rect and siblings); sits between the engines and the single-port frame-buffer RAM.
- Arbitrates up to N_ENG engine request ports and issues one RAM access per granted transfer.
- Returns read data to the requesting engine on a shared broadcast bus, qualified by a per-engine transfer-complete strobe.

Parameters:
- N_ENG, 5, number of engine request ports; index 1 = fill-rect engine.
- AW, 16, address width.
- DW, 32, data width; wben width is DW/8.

Ports:
- clk  in  1  system clock.
- rst_  in  1  reset, asynchronous, active-high (1 = reset), despite the trailing underscore.
- eng_data  in  N_ENG*DW  write data; slice i is engine i.
- eng_addr  in  N_ENG*AW  word address per engine.
- eng_wben  in  N_ENG*(DW/8)  byte write enables per engine.
- eng_op  in  N_ENG  per engine: 1 = write, 0 = read.
- eng_rts  in  N_ENG  per-engine request valid.
- eng_rtr  out  N_ENG  per-engine ready; at most one bit high.
- bcast_data  out  DW  read-return data, shared by all engines.
- bcast_xfc  out  N_ENG  one-cycle completion strobe per engine (reads and writes).
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_wben  out  DW/8  RAM byte enables.
- mem_rdata  in  DW  RAM read data; valid exactly one cycle after mem_en with mem_we=0.

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_ptr = N_ENG-1 so that engine 0 has first priority.
- Handshake: a transfer occurs on a rising edge where eng_rts[i] & eng_rtr[i]. Engines hold rts and payload stable until the transfer.
- State machine:
  - IDLE: if any rts, select the winner by round-robin, searching from rr_ptr+1 upward with wrap. Register grant = winner, set eng_rtr[winner] = 1, go to OFFER. Otherwise stay in IDLE.
  - OFFER: if eng_rts[grant] = 1, capture addr, data, wben and op; clear rtr; set rr_ptr = grant; go to ISSUE. If rts has dropped, clear rtr, leave rr_ptr unchanged, go to IDLE.
  - ISSUE: mem_en = 1, mem_we = op, mem_addr/mem_wdata/mem_wben driven from the captured values; mem_wben is forced to 0 on reads. On a write go to DONE; on a read go to WAIT.
  - WAIT: register mem_rdata into bcast_data; go to DONE.
  - DONE: bcast_xfc[grant] = 1 for one cycle; go to IDLE.
- Latency: rts seen in cycle 0 → rtr in cycle 1 → mem_en in cycle 2.
  - Write: xfc in cycle 3.
  - Read: xfc in cycle 4, with bcast_data valid in cycle 4 and held until the next read.
- bcast_data changes only on reads. A write does not disturb it.
- At most one transaction is in flight. No new rtr is asserted until after DONE.
- Simultaneous requests: exactly one grant. A continuously requesting engine is served again only after every other requesting engine has been served once.
- Reset asserted mid-transaction: all outputs return to 0 immediately. The pending access is dropped with no xfc. rr_ptr returns to N_ENG-1.
- eng_rts bits at index ≥ N_ENG do not exist; widths scale with the parameters.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. rr_ptr is not implemented and the OFFER update is removed.
- Undefined: round-robin as above.
- Timing and handshake are identical in both builds.

Test Plan:
- Single write: engine 1 rts, op=1, addr=0x0010, data=0xDEADBEEF, wben=0xF → mem_en/mem_we high in cycle 2 with these values; bcast_xfc = 5'b00010 in cycle 3; bcast_data unchanged.
- Single read: engine 1, op=0, addr=0x0020, RAM model returns 0x12345678 → mem_we = 0 and mem_wben = 0 in cycle 2; bcast_data = 0x12345678 and xfc[1] high in cycle 4.
- Contention: engines 0, 1 and 3 hold rts continuously with writes → grant order 0, 1, 3, 0, 1, 3, …. With ARB_FIXED_PRIO_EN defined → grants go to 0 only.
- Withdrawal: engine 2 drops rts during OFFER → no mem_en and no xfc; engine 2 keeps priority and is granted on its next request ahead of engine 3.
- Reset mid-read: assert rst_ during WAIT → all outputs 0 at once, no xfc. After release, the first request is served normally and engine 0 has priority.
- Back-to-back: engine 1 issues 4 writes to addresses 0..3 → each completes in 4 cycles (rts → xfc inclusive); no overlap of mem_en between transactions.
